fft_unload: RTL and testbench

- Drains a finished FFT frame from the ping-pong result RAM and streams it out over a valid/ready interface.
- It is the reader at the far end of the RAM that the butterfly address generator writes. It starts when fft_done is asserted and reads all 2^N complex bins in index order.
- It absorbs the RAM's 1-cycle read latency and downstream backpressure without losing or duplicating samples.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_skid_fifo.sv | 68 ++++++
 rtl/fft_unload.sv | 137 +++++++++++++
 tb/tb_fft_unload.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT types and constants: sizes, complex sample layout, unload FSM states
// and the index bit-reversal helper.
package fft_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int N         = 9;
    localparam int POINTS    = 1 << N;

    typedef struct packed {
        logic signed [BIT_WIDTH-1:0] re;
        logic signed [BIT_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        r = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            r[i] = a[N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry FIFO whose head lives directly in a register, so consumers see flop outputs.
module fft_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    // Qualify requests so a pop on empty or a push on a non-draining full FIFO is ignored.
    always_comb begin
        w_pop  = i_pop & (r_count != 2'd0);
        w_push = i_push & ((r_count != 2'd2) | w_pop);
    end

    // Storage update: head is always the oldest entry, tail holds the second one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= {W{1'b0}};
            r_tail  <= {W{1'b0}};
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_din;
                    end else begin
                        r_tail <= i_din;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end else begin
                        r_head <= i_din;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_count = r_count;

endmodule

// File: rtl/fft_unload.sv
// Streams a finished FFT frame out of the result RAM in natural bin order over valid/ready,
// hiding the RAM's one-cycle read latency behind a two-entry skid FIFO.
module fft_unload #(
    parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH,
    parameter int N         = fft_pkg::N,
    parameter int BITREV    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    output logic [N-1:0]           rd_addr,
    output logic                   rd_en,
    output logic                   rd_sel,
    input  logic [2*BIT_WIDTH-1:0] rd_data0,
    input  logic [2*BIT_WIDTH-1:0] rd_data1,
    output logic [2*BIT_WIDTH-1:0] out_data,
    output logic [N-1:0]           out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   unload_done
);
    import fft_pkg::*;

    localparam int   W        = 2*BIT_WIDTH + N + 1;
    // The last butterfly level writes bank 1 when N-1 is even, bank 0 otherwise.
    localparam logic RES_BANK = (((N - 1) % 2) == 0) ? 1'b1 : 1'b0;

    state_t         r_state;
    logic [N-1:0]   r_k;
    logic [N-1:0]   r_k_d;
    logic           r_armed;
    logic           r_inflight;
    logic           r_busy;
    logic           r_done;
    logic           w_rd_en;
    logic           w_pop;
    logic           w_empty;
    logic           w_full;
    logic [1:0]     w_count;
    logic [1:0]     w_credit;
    logic [W-1:0]   w_din;
    logic [W-1:0]   w_head;
    cplx_t          w_word;

    // Read credit: queued words plus the word still in the RAM pipe, less a same-cycle pop.
    always_comb begin
        w_pop    = ~w_empty & out_ready;
        w_credit = w_count + {1'b0, r_inflight} - {1'b0, w_pop};
        if ((r_state == STREAM) && (w_credit < 2'd2) && !(w_full && !w_pop)) begin
            w_rd_en = 1'b1;
        end else begin
            w_rd_en = 1'b0;
        end
    end

    assign w_word = rd_sel ? rd_data1 : rd_data0;
    assign w_din  = {w_word, r_k_d, (r_k_d == {N{1'b1}})};

    fft_skid_fifo #(
        .W (W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_din   (w_din),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Frame sequencer: start on an armed fft_done, walk k, wait out the final beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_armed    <= 1'b1;
            r_k        <= {N{1'b0}};
            r_k_d      <= {N{1'b0}};
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= 1'b0;
            if (w_rd_en) begin
                r_k_d <= r_k;
            end
            if (!fft_done) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (fft_done && r_armed) begin
                        r_state <= STREAM;
                        r_armed <= 1'b0;
                        r_busy  <= 1'b1;
                        r_k     <= {N{1'b0}};
                    end
                end
                STREAM: begin
                    if (w_rd_en) begin
                        if (r_k == {N{1'b1}}) begin
                            r_state <= DRAIN;
                            r_k     <= {N{1'b0}};
                        end else begin
                            r_k <= r_k + N'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head[0]) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_en       = w_rd_en;
    assign rd_addr     = (BITREV != 0) ? bitrev(r_k) : r_k;
    assign rd_sel      = RES_BANK;
    assign out_valid   = ~w_empty;
    assign out_data    = w_head[W-1 -: 2*BIT_WIDTH];
    assign out_index   = w_head[N:1];
    assign out_last    = w_head[0];
    assign busy        = r_busy;
    assign unload_done = r_done;

endmodule

// File: tb/tb_fft_unload.sv
// Directed-plus-random bench for fft_unload: two instances (natural and bit-reversed addressing)
// read a behavioural two-bank RAM; expected beats come from the bin-order rules.
module tb_fft_unload;

    localparam int BW  = 16;
    localparam int NB  = 9;
    localparam int PTS = 512;

    logic            clk = 1'b0;
    logic            reset;
    logic            fft_done;
    logic            out_ready;
    logic [NB-1:0]   rd_addr, br_rd_addr;
    logic            rd_en, br_rd_en, rd_sel, br_rd_sel;
    logic [2*BW-1:0] rd_data0, rd_data1, br_rd_data0, br_rd_data1;
    logic [2*BW-1:0] out_data, br_out_data;
    logic [NB-1:0]   out_index, br_out_index;
    logic            out_valid, br_out_valid, out_last, br_out_last;
    logic            busy, br_busy, unload_done, br_unload_done;

    logic [2*BW-1:0] mem0 [PTS];
    logic [2*BW-1:0] mem1 [PTS];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_unload #(.BIT_WIDTH(BW), .N(NB), .BITREV(0)) dut (
        .clk(clk), .reset(reset), .fft_done(fft_done),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .unload_done(unload_done)
    );

    fft_unload #(.BIT_WIDTH(BW), .N(NB), .BITREV(1)) dut_br (
        .clk(clk), .reset(reset), .fft_done(fft_done),
        .rd_addr(br_rd_addr), .rd_en(br_rd_en), .rd_sel(br_rd_sel),
        .rd_data0(br_rd_data0), .rd_data1(br_rd_data1),
        .out_data(br_out_data), .out_index(br_out_index), .out_valid(br_out_valid),
        .out_ready(out_ready), .out_last(br_out_last), .busy(br_busy), .unload_done(br_unload_done)
    );

    // Result RAM: both banks read together, data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem0[rd_addr];
            rd_data1 <= mem1[rd_addr];
        end
        if (br_rd_en) begin
            br_rd_data0 <= mem0[br_rd_addr];
            br_rd_data1 <= mem1[br_rd_addr];
        end
    end

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < NB; i++) begin
            if (((k >> i) & 1) != 0) r += 1 << (NB - 1 - i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {out_valid, out_last, busy, unload_done, rd_en, out_index, rd_addr, out_data}, 64'd0);
        check({tag, "_br"}, {br_out_valid, br_out_last, br_busy, br_unload_done, br_rd_en,
                             br_out_index, br_rd_addr, br_out_data}, 64'd0);
        check({tag, "_rd_sel"}, {rd_sel, br_rd_sel}, 64'd3);
    endtask

    // Runs one frame from the edge that samples fft_done (cycle 1); mode 0 = always ready,
    // mode 1 = random backpressure with stall bursts; stop_at >= 0 returns mid-frame under stall.
    task automatic stream_frame(input int mode, input int stop_at, output int first_valid, output int done_cyc);
        int k = 0, bk = 0, bi = 0, cyc = 0, burst = 0;
        logic stalled = 1'b0;
        logic [NB-1:0]   p_idx = '0;
        logic [2*BW-1:0] p_data = '0;
        first_valid = -1;
        done_cyc    = -1;
        while (done_cyc < 0 && cyc < 6000) begin
            @(posedge clk); #1; cyc++;
            if (stalled) check("hold_stable", {out_valid, out_index, out_data}, {1'b1, p_idx, p_data});
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (unload_done) begin
                done_cyc = cyc;
                check("beats_at_done", k, PTS);
            end
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (burst > 0) begin
                out_ready = 1'b0;
                burst--;
            end else begin
                case ($urandom_range(0, 3))
                    0: begin out_ready = 1'b0; burst = 2; end
                    1: out_ready = 1'b0;
                    default: out_ready = 1'b1;
                endcase
            end
            #1;
            check("rd_sel", {rd_sel, br_rd_sel}, 64'd3);
            if (br_rd_en) begin
                check("br_rd_addr", br_rd_addr, rev(bi));
                bi++;
            end
            if (stop_at >= 0 && k >= stop_at && out_valid && !out_ready) return;
            if (out_valid && out_ready) begin
                check("index", out_index, k);
                check("data", out_data, mem1[k]);
                check("last", out_last, (k == PTS - 1));
                check("busy", busy, 64'd1);
                k++;
            end
            if (br_out_valid && out_ready) begin
                check("br_index", br_out_index, bk);
                check("br_data", br_out_data, mem1[rev(bk)]);
                bk++;
            end
            stalled = out_valid && !out_ready;
            p_idx   = out_index;
            p_data  = out_data;
        end
        check("frame_completed", (done_cyc > 0), 64'd1);
        check("br_beats", bk, PTS);
    endtask

    initial begin
        int fv, dc, act;
        reset     = 1'b0;
        fft_done  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < PTS; i++) begin
            mem0[i] = 32'hDEAD_DEAD;
            mem1[i] = {16'(i), ~16'(i)};
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        reset = 1'b1;
        @(posedge clk); #1;

        // Full-rate frame with the {k, ~k} pattern, then fft_done held high (~2000 cycles total).
        fft_done = 1'b1;
        stream_frame(0, -1, fv, dc);
        check("first_valid_cycle", fv, 64'd3);
        check("unload_done_cycle", dc, 64'd515);
        @(posedge clk); #1;
        check("post_frame_idle", {busy, unload_done, out_valid}, 64'd0);
        act = 0;
        repeat (1480) begin
            @(posedge clk); #1;
            if (out_valid || busy || rd_en || br_out_valid || br_busy) act++;
        end
        check("held_done_single_frame", act, 64'd0);

        // One-cycle drop re-arms: second frame under random backpressure and random data.
        fft_done = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < PTS; i++) mem1[i] = $urandom;
        fft_done = 1'b1;
        stream_frame(1, -1, fv, dc);
        check("bp_first_valid_cycle", fv, 64'd3);

        // Third frame interrupted by reset at beat 100 while stalled.
        fft_done = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < PTS; i++) mem1[i] = $urandom;
        fft_done = 1'b1;
        stream_frame(1, 100, fv, dc);
        reset = 1'b0;
        #1;
        check_idle("mid_frame_reset");
        for (int i = 0; i < PTS; i++) mem1[i] = $urandom;
        @(posedge clk); #1;
        reset = 1'b1;
        stream_frame(1, -1, fv, dc);
        check("restart_first_valid_cycle", fv, 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
